// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Brief    : Operation encodings, FSM state type and decode helpers shared by
//            the multiply/divide unit, its interface and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    // Multiply/divide operation select. Encoding 3'b111 is undefined and is
    // executed as MD_MUL.
    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULH  = 3'd1,
        MD_MULHU = 3'd2,
        MD_DIV   = 3'd3,
        MD_MOD   = 3'd4,
        MD_DIVU  = 3'd5,
        MD_MODU  = 3'd6
    } MdOp;

    // Control FSM states of the unit.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_PRE  = 3'd2,
        S_DIV_ITER = 3'd3,
        S_DIV_POST = 3'd4,
        S_DONE     = 3'd5
    } md_state_e;

    // Operands are interpreted as two's complement.
    function automatic logic isSignedMd(input MdOp op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_MOD);
    endfunction

    // Operation runs through the iterative divider.
    function automatic logic isDivMd(input MdOp op);
        return (op == MD_DIV) || (op == MD_MOD) || (op == MD_DIVU) || (op == MD_MODU);
    endfunction

    // Operation returns the remainder rather than the quotient.
    function automatic logic isRemMd(input MdOp op);
        return (op == MD_MOD) || (op == MD_MODU);
    endfunction

    // Operation returns the upper half of the double-width product.
    function automatic logic isHighMd(input MdOp op);
        return (op == MD_MULH) || (op == MD_MULHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Request/response handshake bundle between the execute stage
//            (master) and the multiply/divide unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    import muldiv_unit_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    MdOp              op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output flush, in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_div_iter
// Brief    : Unsigned restoring divider datapath, one quotient bit per clock.
//            i_start loads the operands; o_last is high during the cycle whose
//            closing edge performs the final step, after which o_quotient and
//            o_remainder hold the result.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit_div_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_start,
    input  wire logic [WIDTH-1:0] i_dividend,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic                  o_last,
    output logic      [WIDTH-1:0] o_quotient,
    output logic      [WIDTH-1:0] o_remainder
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_STEPS = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_partial;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    always_comb begin
        w_partial = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_partial - {1'b0, r_dvs};
        w_fits    = ~w_diff[WIDTH];
    end

    // Load on start, then one restore-shift-subtract step per cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= c_STEPS;
        end else if (r_cnt != '0) begin
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_last      = (r_cnt == c_ONE);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle integer multiply/divide unit for the execute stage.
//            Multiply completes after MUL_LAT cycles, divide after WIDTH+2
//            cycles (2 for divide-by-zero and signed overflow).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    muldiv_unit_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0]   c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          r_state;
    MdOp                r_op;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_src2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_special;
    logic [WIDTH-1:0]   r_special_res;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;
    logic               r_in_ready;

    logic               w_signed;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic               w_div_start;
    logic               w_div_last;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_div_res;
    logic [2:0]         w_op_bits;

    // Multiply datapath: one double-width product of the latched operands,
    // sign-extended only for MULH so MUL/MULHU share the same multiplier.
    always_comb begin
        w_signed  = isSignedMd(r_op);
        w_mul_a   = {{WIDTH{w_signed & r_src1[WIDTH-1]}}, r_src1};
        w_mul_b   = {{WIDTH{w_signed & r_src2[WIDTH-1]}}, r_src2};
        w_prod    = w_mul_a * w_mul_b;
        w_mul_res = isHighMd(r_op) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
    end

    // Divide pre/post processing: operand magnitudes, special cases, sign fix-up.
    always_comb begin
        w_mag1        = (w_signed && r_src1[WIDTH-1]) ? -r_src1 : r_src1;
        w_mag2        = (w_signed && r_src2[WIDTH-1]) ? -r_src2 : r_src2;
        w_div0        = (r_src2 == '0);
        w_ovf         = w_signed && (r_src1 == c_MOST_NEG) && (r_src2 == c_ALL_ONES);
        w_special     = w_div0 || w_ovf;
        if (w_div0) begin
            w_special_res = isRemMd(r_op) ? r_src1 : c_ALL_ONES;
        end else begin
            w_special_res = isRemMd(r_op) ? '0 : r_src1;
        end
        w_div_start   = (r_state == S_DIV_PRE) && !w_special && !bus.flush;
        if (isRemMd(r_op)) begin
            w_div_res = r_r_neg ? -w_rem : w_rem;
        end else begin
            w_div_res = r_q_neg ? -w_quo : w_quo;
        end
    end

    muldiv_unit_div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (bus.flush),
        .i_start     (w_div_start),
        .i_dividend  (w_mag1),
        .i_divisor   (w_mag2),
        .o_last      (w_div_last),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= MD_MUL;
            r_src1        <= '0;
            r_src2        <= '0;
            r_cnt         <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_special     <= 1'b0;
            r_special_res <= '0;
            r_result      <= '0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
        end else if (bus.flush) begin
            // Result register keeps its last value; out_valid drops.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.op;
                        r_src1     <= bus.src1;
                        r_src2     <= bus.src2;
                        r_in_ready <= 1'b0;
                        if (isDivMd(bus.op)) begin
                            r_state <= S_DIV_PRE;
                        end else begin
                            r_state <= S_MUL;
                            r_cnt   <= c_MUL_LOAD;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_result    <= w_mul_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_DIV_PRE: begin
                    r_q_neg       <= w_signed && (r_src1[WIDTH-1] ^ r_src2[WIDTH-1]);
                    r_r_neg       <= w_signed && r_src1[WIDTH-1];
                    r_special     <= w_special;
                    r_special_res <= w_special_res;
                    // Special cases bypass the iterations and only pass
                    // through the output stage.
                    r_state       <= w_special ? S_DIV_POST : S_DIV_ITER;
                end
                S_DIV_ITER: begin
                    if (w_div_last) begin
                        r_state <= S_DIV_POST;
                    end
                end
                S_DIV_POST: begin
                    r_result    <= r_special ? r_special_res : w_div_res;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    // Undefined operation encodings execute as MUL but are flagged here.
    assign w_op_bits = bus.op;

    a_op_defined: assert property (@(posedge clk) disable iff (rst)
        (bus.in_valid && bus.in_ready && !bus.flush) |-> (w_op_bits != 3'b111));

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=2):
//            directed vectors, corner sequences and random ops vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        MdOp         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] ref_result(input MdOp op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      sp = sa * sb;
        logic [63:0] up = {32'b0, a} * {32'b0, b};
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [63:0] spv = sp;
        case (op)
            MD_MULH:  return spv[63:32];
            MD_MULHU: return up[63:32];
            MD_DIV:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            MD_MOD:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            MD_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_MODU:  return (b == 0) ? a : a % b;
            default:  return up[31:0];
        endcase
    endfunction

    function automatic int ref_latency(input MdOp op, input logic [31:0] a, input logic [31:0] b);
        logic sgn = (op == MD_DIV) || (op == MD_MOD);
        if (!((op == MD_DIV) || (op == MD_MOD) || (op == MD_DIVU) || (op == MD_MODU)))
            return MUL_LAT;
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 2;
        return WIDTH + 2;
    endfunction

    // Present one request and return just after the accepting edge.
    task automatic issue(input MdOp op, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("issue_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid, then compare latency and value.
    task automatic wait_result(input string name, input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_res"}, bus.result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{"mul",      MD_MUL,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 2};
        vecs[1]  = '{"mulh",     MD_MULH,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2};
        vecs[2]  = '{"mulhu",    MD_MULHU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 2};
        vecs[3]  = '{"div_neg",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        vecs[4]  = '{"mod_neg",  MD_MOD,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        vecs[5]  = '{"divu",     MD_DIVU,  32'd100,       32'd7,         32'd14,        34};
        vecs[6]  = '{"modu",     MD_MODU,  32'd100,       32'd7,         32'd2,         34};
        vecs[7]  = '{"divu_z",   MD_DIVU,  32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 2};
        vecs[8]  = '{"mod_z",    MD_MOD,   32'h0000_1234, 32'd0,         32'h0000_1234, 2};
        vecs[9]  = '{"div_ovf",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[10] = '{"mod_ovf",  MD_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2};
        vecs[11] = '{"div_z",    MD_DIV,   32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[12] = '{"modu_z",   MD_MODU,  32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 2};
        vecs[13] = '{"div_pos_neg", MD_DIV, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = MD_MUL;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result",    bus.result,         32'd0);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(vecs[i].name, vecs[i].exp, vecs[i].lat);
        end

        // Flush mid-divide, then a multiply right after
        issue(MD_DIV, 32'd1000, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) check("flush_early_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_in_ready",  32'(bus.in_ready),  32'd1);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        issue(MD_MUL, 32'd3, 32'd5);
        wait_result("after_flush_mul", 32'd15, 2);

        // flush together with in_valid: no accept
        @(negedge clk);
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = MD_MUL;
        bus.src1     = 32'd9;
        bus.src2     = 32'd9;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_noaccept_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("flush_noaccept_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: result held while out_ready is low
        bus.out_ready = 1'b0;
        issue(MD_MUL, 32'd7, 32'd6);
        wait_result("bp_mul", 32'd42, 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_result", bus.result, 32'd42);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        check("bp_result_kept",   bus.result,         32'd42);

        // flush during the output handshake
        issue(MD_MULHU, 32'h8000_0000, 32'd4);
        wait_result("hs_flush_mul", 32'd2, 2);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("hs_flush_valid", 32'(bus.out_valid), 32'd0);
        check("hs_flush_ready", 32'(bus.in_ready),  32'd1);

        // Reset in the middle of the divide iterations
        issue(MD_DIVU, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result",    bus.result,         32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        issue(MD_DIVU, 32'd9, 32'd3);
        wait_result("midrst_divu", 32'd3, 34);

        // Random operations against the reference model
        for (int n = 0; n < 60; n++) begin
            MdOp         rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = MdOp'($urandom_range(0, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: begin
                    ra = $urandom_range(0, 1000);
                    rb = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: ;
            endcase
            issue(rop, ra, rb);
            wait_result($sformatf("rand%0d_%s", n, rop.name()), ref_result(rop, ra, rb),
                        ref_latency(rop, ra, rb));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
